// File: rtl/push_button_debouncer.sv
// ============================================================================
// Module      : push_button_debouncer
// Description : Synchronises, debounces and edge-detects active-low push buttons.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module push_button_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] push_button_n,
    output logic [NUM_BUTTONS-1:0] push_button,
    output logic [NUM_BUTTONS-1:0] pressed_pulse,
    output logic [NUM_BUTTONS-1:0] released_pulse,
    output logic                   any_pressed
);

    localparam logic [1:0] C_ST_RELEASED        = 2'd0;
    localparam logic [1:0] C_ST_PRESS_PENDING   = 2'd1;
    localparam logic [1:0] C_ST_PRESSED         = 2'd2;
    localparam logic [1:0] C_ST_RELEASE_PENDING = 2'd3;

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] push_button_d;
    logic                   any_pressed_q;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   sync_act;
        logic [1:0]             state_q, state_d;
        logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
        logic                   pb_q, pb_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;

        // Sync chain resets to 1 so a released pin never looks like a press.
        always_comb sync_d = {sync_q[SYNC_STAGES-2:0], push_button_n[i]};
        assign sync_act = ~sync_q[SYNC_STAGES-1];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_q    <= '1;
                state_q   <= C_ST_RELEASED;
                cnt_q     <= '0;
                pb_q      <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= sync_d;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pb_q      <= pb_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Any disagreement while pending drops back and clears the count.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                C_ST_RELEASED: begin
                    if (sync_act) begin
                        state_d = C_ST_PRESS_PENDING;
                        cnt_d   = C_CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                C_ST_PRESS_PENDING: begin
                    if (!sync_act) begin
                        state_d = C_ST_RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_d = C_ST_PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                C_ST_PRESSED: begin
                    if (!sync_act) begin
                        state_d = C_ST_RELEASE_PENDING;
                        cnt_d   = C_CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                C_ST_RELEASE_PENDING: begin
                    if (sync_act) begin
                        state_d = C_ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_d = C_ST_RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                default: begin
                    state_d = C_ST_RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            pb_d      = (state_d == C_ST_PRESSED) || (state_d == C_ST_RELEASE_PENDING);
            press_d   = (state_q == C_ST_PRESS_PENDING) && (state_d == C_ST_PRESSED);
            release_d = (state_q == C_ST_RELEASE_PENDING) && (state_d == C_ST_RELEASED);
        end

        assign push_button_d[i]  = pb_d;
        assign push_button[i]    = pb_q;
        assign pressed_pulse[i]  = press_q;
        assign released_pulse[i] = release_q;
    end

    // Built from next-state levels so it lines up with push_button.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            any_pressed_q <= 1'b0;
        end else begin
            any_pressed_q <= |push_button_d;
        end
    end

    assign any_pressed = any_pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_push_button_debouncer.sv
// ============================================================================
// Module      : tb_push_button_debouncer
// Description : Scoreboard bench for push_button_debouncer (SYNC=2, DEBOUNCE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_push_button_debouncer;

    typedef struct packed {
        logic [1:0] pb;
        logic [1:0] pp;
        logic [1:0] rp;
        logic       any;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic [1:0] push_button_n;
    logic [1:0] push_button;
    logic [1:0] pressed_pulse;
    logic [1:0] released_pulse;
    logic       any_pressed;

    int   errors;
    int   checks;
    exp_t sb_q[$];

    push_button_debouncer #(
        .NUM_BUTTONS    (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (16)
    ) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .push_button_n (push_button_n),
        .push_button   (push_button),
        .pressed_pulse (pressed_pulse),
        .released_pulse(released_pulse),
        .any_pressed   (any_pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push_exp(input int n, input logic [1:0] pb, input logic [1:0] pp,
                            input logic [1:0] rp);
        exp_t e;
        e.pb  = pb;
        e.pp  = pp;
        e.rp  = rp;
        e.any = |pb;
        repeat (n) sb_q.push_back(e);
    endtask

    function automatic exp_t observed();
        exp_t o;
        o.pb  = push_button;
        o.pp  = pressed_pulse;
        o.rp  = released_pulse;
        o.any = any_pressed;
        return o;
    endfunction

    task automatic test_reset();
        exp_t got;
        reset_n       = 1'b0;
        push_button_n = 2'b11;
        tick();
        tick();
        got = observed();
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", got, 7'd0);
        end
        reset_n = 1'b1;
        push_exp(10, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 10; k++) begin
            tick();
            got = observed();
            checks++;
            if (got !== sb_q.pop_front()) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b expected 0", k, got);
            end
        end
    endtask

    task automatic test_press();
        exp_t got, e;
        push_button_n = 2'b10;
        push_exp(5, 2'b00, 2'b00, 2'b00);
        push_exp(1, 2'b01, 2'b01, 2'b00);
        push_exp(2, 2'b01, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL press cycle %0d: got pb/pp/rp/any=%b expected %b", k, got, e);
            end
        end
    endtask

    task automatic test_release(input logic [1:0] held);
        exp_t got, e;
        push_button_n = 2'b11;
        push_exp(5, held, 2'b00, 2'b00);
        push_exp(1, 2'b00, 2'b00, held);
        push_exp(2, 2'b00, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL release(%b) cycle %0d: got %b expected %b", held, k, got, e);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t got, e;
        // Low for exactly DEBOUNCE_CYCLES-1 sampled cycles: must be rejected.
        push_button_n = 2'b10;
        push_exp(9, 2'b00, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            if (k == 3) push_button_n = 2'b11;
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL bounce cycle %0d: got %b expected %b", k, got, e);
            end
        end
        push_button_n = 2'b10;
        push_exp(5, 2'b00, 2'b00, 2'b00);
        push_exp(1, 2'b01, 2'b01, 2'b00);
        push_exp(2, 2'b01, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL bounce_then_hold cycle %0d: got %b expected %b", k, got, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t got, e;
        push_button_n = 2'b00;
        push_exp(5, 2'b00, 2'b00, 2'b00);
        push_exp(1, 2'b11, 2'b11, 2'b00);
        push_exp(2, 2'b11, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: got %b expected %b", k, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_qualify();
        exp_t got, e;
        push_button_n = 2'b01;
        push_exp(4, 2'b00, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midreset_pre cycle %0d: got %b expected %b", k, got, e);
            end
        end
        // btn1 now PRESS_PENDING with cnt=2; reset must wipe it with no pulse.
        reset_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL midreset_async: got %b expected %b", got, 7'd0);
        end
        tick();
        tick();
        got = observed();
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL midreset_hold: got %b expected %b", got, 7'd0);
        end
        reset_n = 1'b1;
        push_exp(5, 2'b00, 2'b00, 2'b00);
        push_exp(1, 2'b10, 2'b10, 2'b00);
        push_exp(2, 2'b10, 2'b00, 2'b00);
        for (int k = 0; sb_q.size() > 0; k++) begin
            tick();
            got = observed();
            e   = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midreset_requalify cycle %0d: got %b expected %b", k, got, e);
            end
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_n       = 1'b0;
        push_button_n = 2'b11;
        test_reset();
        test_press();
        test_release(2'b01);
        test_bounce();
        test_release(2'b01);
        test_simultaneous();
        test_release(2'b11);
        test_reset_mid_qualify();
        test_release(2'b10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
